// File: rtl/vanilla_bubble_profiler_pkg.sv
// vanilla_bubble_profiler_pkg: shared type codes, the cause-vector code base,
// the ID-stage bubble enum and a safe clog2 helper for the bubble profiler.
package vanilla_bubble_profiler_pkg;

   // Fixed bubble type codes; generic stall causes start at bp_cause_base_gp.
   localparam int unsigned e_bp_no_bubble   = 0;
   localparam int unsigned e_bp_branch_miss = 1;
   localparam int unsigned e_bp_jalr_miss   = 2;
   localparam int unsigned e_bp_icache_miss = 3;
   localparam int unsigned bp_cause_base_gp = 4;

   // Front-end bubbles tracked in ID; encodings equal the EXE type codes.
   typedef enum logic [1:0] {
      e_id_no_bubble   = 2'd0,
      e_id_branch_miss = 2'd1,
      e_id_jalr_miss   = 2'd2,
      e_id_icache_miss = 2'd3
   } bp_id_bubble_e;

   // Width needed to index n entries, never less than 1.
   function automatic int unsigned bp_safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_priority_encode.sv
// bsg_priority_encode: index of the highest-priority set bit of i.
// lo_to_hi_p=1 gives bit 0 the highest priority; v_o flags any bit set.
module bsg_priority_encode #(
   parameter  int unsigned width_p       = 1,
   parameter  int unsigned lo_to_hi_p    = 1,
   localparam int unsigned addr_width_lp = (width_p <= 1) ? 1 : $clog2(width_p)
) (
   input  logic [width_p-1:0]       i,
   output logic [addr_width_lp-1:0] addr_o,
   output logic                     v_o
);

   // First set bit in priority order wins.
   always_comb begin
      logic found;
      int unsigned idx;
      addr_o = '0;
      v_o    = |i;
      found  = 1'b0;
      for (int unsigned k = 0; k < width_p; k++) begin
         idx = (lo_to_hi_p != 0) ? k : (width_p - 1 - k);
         if (!found && i[idx]) begin
            addr_o = addr_width_lp'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vanilla_bubble_profiler_counter_bank.sv
// vanilla_bubble_counter_bank: saturating per-type bubble counters with a
// synchronous clear and a registered one-cycle read port. Reads return the
// value before any same-cycle increment or clear; out-of-range reads return 0.
module vanilla_bubble_counter_bank
   import vanilla_bubble_profiler_pkg::*;
#(
   parameter  int unsigned els_p         = 28,
   parameter  int unsigned width_p       = 32,
   localparam int unsigned addr_width_lp = bp_safe_clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clear_i,
   input  logic                     inc_v_i,
   input  logic [addr_width_lp-1:0] inc_addr_i,
   input  logic                     rd_v_i,
   input  logic [addr_width_lp-1:0] rd_addr_i,
   output logic                     rd_v_o,
   output logic [width_p-1:0]       rd_data_o
);

   logic [width_p-1:0] ctr_q [els_p];
   logic [width_p-1:0] ctr_d [els_p];
   logic               rd_v_q, rd_v_d;
   logic [width_p-1:0] rd_data_q, rd_data_d;

   // Counter update: clear beats increment; increments stop at all-ones.
   always_comb begin
      for (int unsigned k = 0; k < els_p; k++) begin
         ctr_d[k] = ctr_q[k];
         if (clear_i) begin
            ctr_d[k] = '0;
         end else if (inc_v_i && (addr_width_lp'(k) == inc_addr_i) && (ctr_q[k] != '1)) begin
            ctr_d[k] = ctr_q[k] + width_p'(1);
         end
      end
   end

   // Read lookup against current (pre-update) counter values.
   always_comb begin
      rd_v_d    = rd_v_i;
      rd_data_d = '0;
      if (rd_v_i) begin
         for (int unsigned k = 0; k < els_p; k++) begin
            if (addr_width_lp'(k) == rd_addr_i) begin
               rd_data_d = ctr_q[k];
            end
         end
      end
   end

   // Counter and read-port registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned k = 0; k < els_p; k++) begin
            ctr_q[k] <= '0;
         end
         rd_v_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         for (int unsigned k = 0; k < els_p; k++) begin
            ctr_q[k] <= ctr_d[k];
         end
         rd_v_q    <= rd_v_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_v_o    = rd_v_q;
   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vanilla_bubble_profiler.sv
// vanilla_bubble_profiler: classifies the instruction in EXE as a bubble type
// (front-end mispredict/icache miss tracked through ID, or a generic stall
// cause) and records its PC. Per-type counters and the read port exist only
// when VANILLA_BUBBLE_PROFILER_COUNTERS_EN is defined.
module vanilla_bubble_profiler
   import vanilla_bubble_profiler_pkg::*;
#(
   parameter  int unsigned data_width_p  = 32,
   parameter  int unsigned num_causes_p  = 24,
   parameter  int unsigned ctr_width_p   = 32,
   localparam int unsigned type_width_lp = bp_safe_clog2(num_causes_p + bp_cause_base_gp)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [data_width_p-1:0]  if_pc_i,
   input  logic [data_width_p-1:0]  id_pc_i,
   input  logic [data_width_p-1:0]  exe_pc_i,
   input  logic                     stall_all_i,
   input  logic                     icache_miss_i,
   input  logic                     icache_miss_in_pipe_i,
   input  logic                     branch_mispredict_i,
   input  logic                     jalr_mispredict_i,
   input  logic [num_causes_p-1:0]  stall_cause_i,
   input  logic                     clear_i,
   input  logic                     rd_v_i,
   input  logic [type_width_lp-1:0] rd_addr_i,
   output logic [type_width_lp-1:0] exe_bubble_type_o,
   output logic [data_width_p-1:0]  exe_bubble_pc_o,
   output logic                     rd_v_o,
   output logic [ctr_width_p-1:0]   rd_data_o
);

   localparam int unsigned num_types_lp       = num_causes_p + bp_cause_base_gp;
   localparam int unsigned cause_addr_width_lp = bp_safe_clog2(num_causes_p);

   logic [data_width_p-1:0]        icache_miss_pc_q, icache_miss_pc_d;
   bp_id_bubble_e                  id_type_q, id_type_d;
   logic [data_width_p-1:0]        id_pc_q, id_pc_d;
   logic [type_width_lp-1:0]       exe_type_q, exe_type_d;
   logic [data_width_p-1:0]        exe_pc_q, exe_pc_d;
   logic [cause_addr_width_lp-1:0] cause_addr;
   logic                           cause_v;

   bsg_priority_encode #(
      .width_p   (num_causes_p),
      .lo_to_hi_p(1)
   ) cause_penc (
      .i     (stall_cause_i),
      .addr_o(cause_addr),
      .v_o   (cause_v)
   );

   // Remember the PC of the latest icache miss, even while frozen.
   always_comb begin
      icache_miss_pc_d = icache_miss_pc_q;
      if (icache_miss_i) begin
         icache_miss_pc_d = if_pc_i;
      end
   end

   // ID bubble: a mispredict resolving in EXE flushes ID; else an icache-miss bubble.
   always_comb begin
      id_type_d = id_type_q;
      id_pc_d   = id_pc_q;
      if (!stall_all_i) begin
         if (branch_mispredict_i) begin
            id_type_d = e_id_branch_miss;
            id_pc_d   = exe_pc_i;
         end else if (jalr_mispredict_i) begin
            id_type_d = e_id_jalr_miss;
            id_pc_d   = exe_pc_i;
         end else if (icache_miss_in_pipe_i) begin
            id_type_d = e_id_icache_miss;
            id_pc_d   = icache_miss_pc_q;
         end else begin
            id_type_d = e_id_no_bubble;
            id_pc_d   = '0;
         end
      end
   end

   // EXE bubble: mispredict, then the bubble carried from ID, then the lowest stall cause.
   always_comb begin
      exe_type_d = exe_type_q;
      exe_pc_d   = exe_pc_q;
      if (!stall_all_i) begin
         if (branch_mispredict_i) begin
            exe_type_d = type_width_lp'(e_bp_branch_miss);
            exe_pc_d   = exe_pc_i;
         end else if (jalr_mispredict_i) begin
            exe_type_d = type_width_lp'(e_bp_jalr_miss);
            exe_pc_d   = exe_pc_i;
         end else if (id_type_q != e_id_no_bubble) begin
            exe_type_d = type_width_lp'(id_type_q);
            exe_pc_d   = id_pc_q;
         end else if (cause_v) begin
            exe_type_d = type_width_lp'(bp_cause_base_gp) + type_width_lp'(cause_addr);
            exe_pc_d   = id_pc_i;
         end else begin
            exe_type_d = type_width_lp'(e_bp_no_bubble);
            exe_pc_d   = '0;
         end
      end
   end

   // Classification state registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         icache_miss_pc_q <= '0;
         id_type_q        <= e_id_no_bubble;
         id_pc_q          <= '0;
         exe_type_q       <= '0;
         exe_pc_q         <= '0;
      end else begin
         icache_miss_pc_q <= icache_miss_pc_d;
         id_type_q        <= id_type_d;
         id_pc_q          <= id_pc_d;
         exe_type_q       <= exe_type_d;
         exe_pc_q         <= exe_pc_d;
      end
   end

   assign exe_bubble_type_o = exe_type_q;
   assign exe_bubble_pc_o   = exe_pc_q;

`ifdef VANILLA_BUBBLE_PROFILER_COUNTERS_EN
   // Every unfrozen cycle charges the type now in EXE, including no_bubble.
   vanilla_bubble_counter_bank #(
      .els_p  (num_types_lp),
      .width_p(ctr_width_p)
   ) counter_bank (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clear_i   (clear_i),
      .inc_v_i   (~stall_all_i),
      .inc_addr_i(exe_type_q),
      .rd_v_i    (rd_v_i),
      .rd_addr_i (rd_addr_i),
      .rd_v_o    (rd_v_o),
      .rd_data_o (rd_data_o)
   );
`else
   logic unused_counter_ports;
   assign unused_counter_ports = ^{clear_i, rd_v_i, rd_addr_i};
   assign rd_v_o    = 1'b0;
   assign rd_data_o = '0;
`endif

endmodule

// File: tb/tb_vanilla_bubble_profiler.sv
// Scoreboard bench for vanilla_bubble_profiler: a driver applies stimulus and
// pushes the reference model's expected post-edge outputs; a monitor pops and
// compares them each cycle. Counter expectations apply only when
// VANILLA_BUBBLE_PROFILER_COUNTERS_EN is defined.
module tb_vanilla_bubble_profiler;

   localparam int unsigned DW   = 32;
   localparam int unsigned NC   = 8;
   localparam int unsigned CW   = 4;
   localparam int unsigned TW   = 4;
   localparam int unsigned NT   = NC + 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk;
   logic          reset_i;
   logic [DW-1:0] if_pc_i, id_pc_i, exe_pc_i;
   logic          stall_all_i, icache_miss_i, icache_miss_in_pipe_i;
   logic          branch_mispredict_i, jalr_mispredict_i;
   logic [NC-1:0] stall_cause_i;
   logic          clear_i, rd_v_i;
   logic [TW-1:0] rd_addr_i;
   logic [TW-1:0] exe_bubble_type_o;
   logic [DW-1:0] exe_bubble_pc_o;
   logic          rd_v_o;
   logic [CW-1:0] rd_data_o;

   vanilla_bubble_profiler #(
      .data_width_p(DW),
      .num_causes_p(NC),
      .ctr_width_p (CW)
   ) dut (
      .clk_i                (clk),
      .reset_i              (reset_i),
      .if_pc_i              (if_pc_i),
      .id_pc_i              (id_pc_i),
      .exe_pc_i             (exe_pc_i),
      .stall_all_i          (stall_all_i),
      .icache_miss_i        (icache_miss_i),
      .icache_miss_in_pipe_i(icache_miss_in_pipe_i),
      .branch_mispredict_i  (branch_mispredict_i),
      .jalr_mispredict_i    (jalr_mispredict_i),
      .stall_cause_i        (stall_cause_i),
      .clear_i              (clear_i),
      .rd_v_i               (rd_v_i),
      .rd_addr_i            (rd_addr_i),
      .exe_bubble_type_o    (exe_bubble_type_o),
      .exe_bubble_pc_o      (exe_bubble_pc_o),
      .rd_v_o               (rd_v_o),
      .rd_data_o            (rd_data_o)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [TW-1:0] typ;
      logic [DW-1:0] pc;
      logic          rd_v;
      logic [CW-1:0] rd_data;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   bit          mon_on   = 1'b1;

   // Reference model state: what each pipeline slot holds, and counts per type.
   logic [DW-1:0] m_icpc;
   int unsigned   m_id_t;
   logic [DW-1:0] m_id_pc;
   int unsigned   m_ex_t;
   logic [DW-1:0] m_ex_pc;
   int unsigned   m_ctr[NT];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic set_idle();
      if_pc_i               = DW'($urandom) & ~DW'(3);
      id_pc_i               = DW'($urandom) & ~DW'(3);
      exe_pc_i              = DW'($urandom) & ~DW'(3);
      stall_all_i           = 1'b0;
      icache_miss_i         = 1'b0;
      icache_miss_in_pipe_i = 1'b0;
      branch_mispredict_i   = 1'b0;
      jalr_mispredict_i     = 1'b0;
      stall_cause_i         = '0;
      clear_i               = 1'b0;
      rd_v_i                = 1'b0;
      rd_addr_i             = '0;
   endtask

   // Evaluate one clock of the model with the inputs now applied, queue the
   // expected outputs after the coming edge, then advance to the next negedge.
   task automatic tick();
      exp_t          e;
      int unsigned   nt, nid;
      logic [DW-1:0] npc, nidpc;
      int unsigned   rd_val;
      e = '0;
      if (reset_i) begin
         m_icpc = '0; m_id_t = 0; m_id_pc = '0; m_ex_t = 0; m_ex_pc = '0;
         for (int k = 0; k < NT; k++) m_ctr[k] = 0;
      end else begin
         rd_val = (int'(rd_addr_i) < int'(NT)) ? m_ctr[rd_addr_i] : 0;
`ifdef VANILLA_BUBBLE_PROFILER_COUNTERS_EN
         e.rd_v    = rd_v_i;
         e.rd_data = CW'(rd_val);
`endif
         if (!stall_all_i) begin
            nt = 0; npc = '0;
            if (branch_mispredict_i) begin nt = 1; npc = exe_pc_i; end
            else if (jalr_mispredict_i) begin nt = 2; npc = exe_pc_i; end
            else if (m_id_t != 0) begin nt = m_id_t; npc = m_id_pc; end
            else begin
               for (int k = 0; k < NC; k++) begin
                  if (stall_cause_i[k]) begin nt = 4 + k; npc = id_pc_i; break; end
               end
            end
            nid = 0; nidpc = '0;
            if (branch_mispredict_i) begin nid = 1; nidpc = exe_pc_i; end
            else if (jalr_mispredict_i) begin nid = 2; nidpc = exe_pc_i; end
            else if (icache_miss_in_pipe_i) begin nid = 3; nidpc = m_icpc; end
            if (m_ctr[m_ex_t] < CMAX) m_ctr[m_ex_t]++;
            m_ex_t = nt; m_ex_pc = npc; m_id_t = nid; m_id_pc = nidpc;
         end
         if (clear_i) for (int k = 0; k < NT; k++) m_ctr[k] = 0;
         if (icache_miss_i) m_icpc = if_pc_i;
      end
      e.typ = TW'(m_ex_t);
      e.pc  = m_ex_pc;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one expected entry per cycle, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("exe_bubble_type", 64'(exe_bubble_type_o), 64'(e.typ));
               chk("exe_bubble_pc", 64'(exe_bubble_pc_o), 64'(e.pc));
               chk("rd_v", 64'(rd_v_o), 64'(e.rd_v));
               if (e.rd_v) chk("rd_data", 64'(rd_data_o), 64'(e.rd_data));
            end
         end
      end
   end

   initial begin
      set_idle();
      reset_i = 1'b1;
      #2;
      chk("reset_type", 64'(exe_bubble_type_o), 64'd0);
      chk("reset_pc", 64'(exe_bubble_pc_o), 64'd0);
      chk("reset_rd_v", 64'(rd_v_o), 64'd0);
      chk("reset_rd_data", 64'(rd_data_o), 64'd0);
      @(negedge clk);
      tick(); tick();
      reset_i = 1'b0;

      // Branch mispredict at 0x100, then read counter[1].
      set_idle(); clear_i = 1'b1; tick();
      set_idle(); branch_mispredict_i = 1'b1; exe_pc_i = 32'h100; tick();
      set_idle(); tick();
      set_idle(); tick();
      set_idle(); rd_v_i = 1'b1; rd_addr_i = 4'd1; tick();

      // Icache miss at 0x200 reaches EXE despite a stall cause bit.
      set_idle(); icache_miss_i = 1'b1; if_pc_i = 32'h200; tick();
      set_idle(); icache_miss_in_pipe_i = 1'b1; stall_cause_i = 8'b0000_0100; tick();
      set_idle(); stall_cause_i = 8'b0000_0100; tick();
      set_idle(); tick();

      // Cause priority, then a 3-cycle freeze with a read of counter[5].
      set_idle(); stall_cause_i = 8'b0000_0110; id_pc_i = 32'h40; tick();
      for (int unsigned i = 0; i < 3; i++) begin
         set_idle(); stall_all_i = 1'b1; branch_mispredict_i = 1'b1;
         icache_miss_in_pipe_i = 1'b1; stall_cause_i = 8'hFF;
         rd_v_i = (i == 2); rd_addr_i = 4'd5; tick();
      end
      set_idle(); rd_v_i = 1'b1; rd_addr_i = 4'd5; tick();

      // Saturation of counter[4].
      set_idle(); clear_i = 1'b1; tick();
      for (int unsigned i = 0; i < 20; i++) begin
         set_idle(); stall_cause_i = 8'b0000_0001; tick();
      end
      set_idle(); stall_cause_i = 8'b0000_0001; rd_v_i = 1'b1; rd_addr_i = 4'd4; tick();

      // Clear colliding with an increment and a read of the same counter.
      set_idle(); stall_cause_i = 8'b0000_0001; clear_i = 1'b1;
      rd_v_i = 1'b1; rd_addr_i = 4'd4; tick();
      set_idle(); rd_v_i = 1'b1; rd_addr_i = 4'd4; tick();

      // Out-of-range read address.
      set_idle(); rd_v_i = 1'b1; rd_addr_i = 4'd13; tick();

      // Reset the cycle after a read.
      set_idle(); rd_v_i = 1'b1; rd_addr_i = 4'd0; tick();
      set_idle(); reset_i = 1'b1;
      #1;
      chk("midreset_type", 64'(exe_bubble_type_o), 64'd0);
      chk("midreset_pc", 64'(exe_bubble_pc_o), 64'd0);
      chk("midreset_rd_v", 64'(rd_v_o), 64'd0);
      chk("midreset_rd_data", 64'(rd_data_o), 64'd0);
      tick();
      reset_i = 1'b0;

      // Randomized traffic.
      for (int unsigned c = 0; c < 1500; c++) begin
         set_idle();
         stall_all_i           = ($urandom_range(0, 4) == 0);
         branch_mispredict_i   = ($urandom_range(0, 9) == 0);
         jalr_mispredict_i     = ($urandom_range(0, 9) == 0);
         icache_miss_i         = ($urandom_range(0, 4) == 0);
         icache_miss_in_pipe_i = ($urandom_range(0, 4) == 0);
         stall_cause_i         = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
         clear_i               = !stall_all_i && ($urandom_range(0, 29) == 0);
         rd_v_i                = 1'($urandom_range(0, 1));
         rd_addr_i             = TW'($urandom_range(0, 15));
         tick();
      end
      set_idle();
      tick();
      mon_on = 1'b0;
      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
